// File: rtl/writeback_buffer_if.sv
// Execute-to-regfile bundle interface for writeback_buffer.
// Upstream (master) drives flush and the in_* bundle; the buffer (slave) drives in_ready, wr_* and count.
interface writeback_buffer_if #(
  parameter int NUM_IN = 5,
  parameter int NUM_WR = 2,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 64,
  parameter int DST_W  = 6
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Handshake: a bundle is taken on a posedge where in_ready && !flush; upstream
  // holds in_* unchanged while in_ready is low. in_ready never looks at in_valid.
  // wr_* has no ready: every asserted wr_valid bit is a completed regfile write.
  logic                     flush;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*DST_W-1:0]  in_dst;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic                     in_ready;
  logic [NUM_WR-1:0]        wr_valid;
  logic [NUM_WR*DST_W-1:0]  wr_dst;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]         count;

  modport master (
    output flush, in_valid, in_dst, in_data,
    input  in_ready, wr_valid, wr_dst, wr_data, count
  );

  modport slave (
    input  flush, in_valid, in_dst, in_data,
    output in_ready, wr_valid, wr_dst, wr_data, count
  );
endinterface

// File: rtl/writeback_buffer.sv
// Compacting writeback FIFO between execute and the regfile write ports.
// Optional feature macro WB_BYPASS_EN: zero-latency writeback when the buffer is empty.
module writeback_buffer #(
  parameter int NUM_IN = 5,
  parameter int NUM_WR = 2,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 64,
  parameter int DST_W  = 6
) (
  input logic              clk,
  input logic              reset,
  writeback_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = DST_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] NUM_IN_C = CNT_W'(NUM_IN);
  localparam logic [CNT_W-1:0] NUM_WR_C = CNT_W'(NUM_WR);

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_ready;
  logic             w_quiet;
  logic             w_push_en;
  logic [CNT_W-1:0] w_slot_off [NUM_IN];
  logic [CNT_W-1:0] w_n_valid;
  logic [CNT_W-1:0] w_n_skip;
  logic [CNT_W-1:0] w_n_push;
  logic [CNT_W-1:0] w_n_pop;
  logic [NUM_IN-1:0] w_enq;
  logic [PTR_W-1:0] w_enq_addr [NUM_IN];

  // Only the registered count is used, so a same-cycle drain never earns credit.
  assign w_ready   = (DEPTH_C - r_count) >= NUM_IN_C;
  assign w_quiet   = reset || bus.flush;
  assign w_push_en = w_ready && !w_quiet;
  assign w_n_pop   = (r_count < NUM_WR_C) ? r_count : NUM_WR_C;

  // Rank of each slot among the valid slots below it gives its compacted position.
  always_comb begin
    w_n_valid = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_slot_off[i] = w_n_valid;
      w_n_valid     = w_n_valid + CNT_W'(bus.in_valid[i]);
    end
  end

`ifdef WB_BYPASS_EN
  logic w_byp_en;
  assign w_byp_en = (r_count == '0) && w_push_en;
  assign w_n_skip = !w_byp_en ? '0 : ((w_n_valid < NUM_WR_C) ? w_n_valid : NUM_WR_C);
`else
  assign w_n_skip = '0;
`endif

  assign w_n_push = w_push_en ? (w_n_valid - w_n_skip) : '0;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      w_enq[i]      = w_push_en && bus.in_valid[i] && (w_slot_off[i] >= w_n_skip);
      w_enq_addr[i] = r_tail + PTR_W'(w_slot_off[i] - w_n_skip);
    end
  end

  always_comb begin
    bus.wr_valid = '0;
    bus.wr_dst   = '0;
    bus.wr_data  = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (!w_quiet && (CNT_W'(k) < w_n_pop)) begin
        bus.wr_valid[k]                 = 1'b1;
        bus.wr_dst[k*DST_W +: DST_W]    = r_mem[r_head + PTR_W'(k)][ENT_W-1:DATA_W];
        bus.wr_data[k*DATA_W +: DATA_W] = r_mem[r_head + PTR_W'(k)][DATA_W-1:0];
      end
    end
`ifdef WB_BYPASS_EN
    // Buffer is empty here, so the first valid slots own the write ports outright.
    if (w_byp_en) begin
      for (int k = 0; k < NUM_WR; k++) begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (bus.in_valid[i] && (w_slot_off[i] == CNT_W'(k))) begin
            bus.wr_valid[k]                 = 1'b1;
            bus.wr_dst[k*DST_W +: DST_W]    = bus.in_dst[i*DST_W +: DST_W];
            bus.wr_data[k*DATA_W +: DATA_W] = bus.in_data[i*DATA_W +: DATA_W];
          end
        end
      end
    end
`endif
  end

  assign bus.in_ready = w_ready;
  assign bus.count    = r_count;

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_n_pop);
      r_tail  <= r_tail + PTR_W'(w_n_push);
      r_count <= r_count + w_n_push - w_n_pop;
    end
  end

  // Storage is not reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_enq[i]) begin
        r_mem[w_enq_addr[i]] <= {bus.in_dst[i*DST_W +: DST_W], bus.in_data[i*DATA_W +: DATA_W]};
      end
    end
  end
endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: scoreboard queue of expected regfile writes plus cycle checks.
// Cycle-level expectations follow WB_BYPASS_EN when it is defined for the build.
module tb_writeback_buffer;
  localparam int NUM_IN = 5;
  localparam int NUM_WR = 2;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 64;
  localparam int DST_W  = 6;
  localparam int ENT_W  = DST_W + DATA_W;

  logic clk;
  logic reset;

  writeback_buffer_if #(.NUM_IN(NUM_IN), .NUM_WR(NUM_WR), .DEPTH(DEPTH),
                        .DATA_W(DATA_W), .DST_W(DST_W)) bus ();

  writeback_buffer #(.NUM_IN(NUM_IN), .NUM_WR(NUM_WR), .DEPTH(DEPTH),
                     .DATA_W(DATA_W), .DST_W(DST_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [ENT_W-1:0] exp_q[$];

  logic [DST_W-1:0]  s_dst  [NUM_IN];
  logic [DATA_W-1:0] s_data [NUM_IN];

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_tag(input int tag);
    for (int i = 0; i < NUM_IN; i++) begin
      s_dst[i]  = DST_W'(tag * 5 + i);
      s_data[i] = {32'(tag), 32'(i)} ^ 64'hC0DE_0000_0000_0000;
    end
  endtask

  task automatic apply(input logic [NUM_IN-1:0] v);
    bus.in_valid = v;
    for (int i = 0; i < NUM_IN; i++) begin
      bus.in_dst[i*DST_W +: DST_W]    = s_dst[i];
      bus.in_data[i*DATA_W +: DATA_W] = s_data[i];
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready with the bundle held, records expected writes, returns one cycle later.
  task automatic commit(input bit at_neg);
    for (int c = 0; c < 60; c++) begin
      if (!(at_neg && c == 0)) @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        for (int i = 0; i < NUM_IN; i++)
          if (bus.in_valid[i]) exp_q.push_back({s_dst[i], s_data[i]});
        to_drive();
        bus.in_valid = '0;
        return;
      end
      to_drive();
    end
    n_checks++;
    n_errors++;
    $display("FAIL accept_timeout: got in_ready low for 60 cycles expected high");
    bus.in_valid = '0;
  endtask

  task automatic send(input logic [NUM_IN-1:0] v, input int tag);
    load_tag(tag);
    apply(v);
    commit(1'b0);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (bus.count == '0) done = 1'b1;
    end
    #2;
    check({name, "_count_zero"}, 64'(done), 64'd1);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    to_drive();
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [ENT_W-1:0] got;
    logic [ENT_W-1:0] exp;
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.wr_valid[k] === 1'b1) begin
          got = {bus.wr_dst[k*DST_W +: DST_W], bus.wr_data[k*DATA_W +: DATA_W]};
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL wr_port%0d_unexpected: got %0h expected no write", k, got);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              n_errors++;
              $display("FAIL wr_port%0d_entry: got %0h expected %0h", k, got, exp);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.flush    = 1'b0;
    bus.in_valid = '0;
    bus.in_dst   = '0;
    bus.in_data  = '0;

    // Reset held two cycles with a full bundle presented.
    reset = 1'b1;
    load_tag(1);
    apply(5'b11111);
    @(negedge clk);
    check("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    to_drive();
    @(negedge clk);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_wr_valid2", 64'(bus.wr_valid), 64'd0);
    to_drive();
    reset = 1'b0;
    bus.in_valid = '0;
    @(negedge clk);
    check("post_rst_count", 64'(bus.count), 64'd0);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    to_drive();
    @(negedge clk);
    check("post_rst_nothing_enq", 64'(bus.count), 64'd0);
    to_drive();

    // Compaction of slots 0,2,4.
    for (int i = 0; i < NUM_IN; i++) begin
      s_dst[i]  = '0;
      s_data[i] = '0;
    end
    s_dst[0] = 6'd1; s_data[0] = 64'hA;
    s_dst[2] = 6'd3; s_data[2] = 64'hB;
    s_dst[4] = 6'd5; s_data[4] = 64'hC;
    apply(5'b10101);
    commit(1'b0);
    @(negedge clk);
`ifdef WB_BYPASS_EN
    check("cmp_c1_count", 64'(bus.count), 64'd1);
    check("cmp_c1_wr_valid", 64'(bus.wr_valid), 64'b01);
    check("cmp_c1_wr0_dst", 64'(bus.wr_dst[DST_W-1:0]), 64'd5);
    to_drive();
    @(negedge clk);
    check("cmp_c2_count", 64'(bus.count), 64'd0);
    check("cmp_c2_wr_valid", 64'(bus.wr_valid), 64'b00);
`else
    check("cmp_c1_count", 64'(bus.count), 64'd3);
    check("cmp_c1_wr_valid", 64'(bus.wr_valid), 64'b11);
    check("cmp_c1_wr0_dst", 64'(bus.wr_dst[DST_W-1:0]), 64'd1);
    check("cmp_c1_wr0_data", bus.wr_data[DATA_W-1:0], 64'hA);
    check("cmp_c1_wr1_dst", 64'(bus.wr_dst[2*DST_W-1:DST_W]), 64'd3);
    to_drive();
    @(negedge clk);
    check("cmp_c2_wr_valid", 64'(bus.wr_valid), 64'b01);
    check("cmp_c2_wr0_dst", 64'(bus.wr_dst[DST_W-1:0]), 64'd5);
    check("cmp_c2_wr0_data", bus.wr_data[DATA_W-1:0], 64'hC);
    to_drive();
    @(negedge clk);
    check("cmp_c3_count", 64'(bus.count), 64'd0);
`endif
    drain("cmp");

    // Backpressure: full bundles back to back, order checked across the wrap.
    for (int b = 0; b < 4; b++) send(5'b11111, 10 + b);
    @(negedge clk);
`ifdef WB_BYPASS_EN
    check("bp_count_after4", 64'(bus.count), 64'd12);
`else
    check("bp_count_after4", 64'(bus.count), 64'd14);
`endif
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    to_drive();
    for (int b = 4; b < 8; b++) send(5'b11111, 10 + b);
    drain("bp");

    // Flush with count=7 and a full bundle presented.
    send(5'b11111, 20);
    send(5'b01111, 21);
`ifdef WB_BYPASS_EN
    send(5'b01111, 22);
`endif
    bus.flush = 1'b1;
    load_tag(23);
    apply(5'b11111);
    exp_q.delete();
    @(negedge clk);
    check("fl_count_before", 64'(bus.count), 64'd7);
    check("fl_wr_valid_same", 64'(bus.wr_valid), 64'd0);
    to_drive();
    bus.flush    = 1'b0;
    bus.in_valid = '0;
    @(negedge clk);
    check("fl_count_after", 64'(bus.count), 64'd0);
    check("fl_wr_valid_after", 64'(bus.wr_valid), 64'd0);
    repeat (3) to_drive();
    drain("fl");

    // Simultaneous push/pop with count=2 at the head wrap.
    for (int b = 0; b < 3; b++) begin
      send(5'b11111, 30 + b);
      drain("pre_wrap");
    end
`ifdef WB_BYPASS_EN
    send(5'b01111, 33);
`else
    send(5'b00011, 33);
`endif
    load_tag(34);
    apply(5'b00111);
    @(negedge clk);
    check("sp_count_two", 64'(bus.count), 64'd2);
    check("sp_wr_valid_two", 64'(bus.wr_valid), 64'b11);
    commit(1'b1);
    @(negedge clk);
    check("sp_count_three", 64'(bus.count), 64'd3);
    to_drive();
    drain("sp");

    // Empty buffer, three valid slots: same-cycle writeback only with bypass.
    for (int i = 0; i < NUM_IN; i++) begin
      s_dst[i]  = DST_W'(2 * (i + 1));
      s_data[i] = 64'h100 + 64'(i);
    end
    apply(5'b00111);
    @(negedge clk);
`ifdef WB_BYPASS_EN
    check("byp_same_wr_valid", 64'(bus.wr_valid), 64'b11);
    check("byp_same_wr0_dst", 64'(bus.wr_dst[DST_W-1:0]), 64'd2);
    check("byp_same_wr1_dst", 64'(bus.wr_dst[2*DST_W-1:DST_W]), 64'd4);
    commit(1'b1);
    @(negedge clk);
    check("byp_next_count", 64'(bus.count), 64'd1);
    check("byp_next_wr_valid", 64'(bus.wr_valid), 64'b01);
    check("byp_next_wr0_dst", 64'(bus.wr_dst[DST_W-1:0]), 64'd6);
    to_drive();
    @(negedge clk);
    check("byp_last_count", 64'(bus.count), 64'd0);
`else
    check("byp_same_wr_valid", 64'(bus.wr_valid), 64'b00);
    commit(1'b1);
    @(negedge clk);
    check("byp_next_count", 64'(bus.count), 64'd3);
    check("byp_next_wr_valid", 64'(bus.wr_valid), 64'b11);
    check("byp_next_wr0_dst", 64'(bus.wr_dst[DST_W-1:0]), 64'd2);
    to_drive();
    @(negedge clk);
    check("byp_last_wr_valid", 64'(bus.wr_valid), 64'b01);
    check("byp_last_wr0_dst", 64'(bus.wr_dst[DST_W-1:0]), 64'd6);
`endif
    to_drive();
    drain("byp");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
